// File: rtl/fetch_branch_unit_if.sv
// fetch_branch_unit_if: fetch-stage bundle linking counter stage, instruction memory and execute
interface fetch_branch_unit_if;
  logic [11:0] pc;
  logic [15:0] imem_data;
  logic zero_flag;
  logic load;
  logic [11:0] d;
  logic [15:0] ir;
  logic [11:0] ir_pc;
  logic ir_valid;
  logic stack_err;
  modport master (output pc, imem_data, zero_flag, input load, d, ir, ir_pc, ir_valid, stack_err);
  modport slave (input pc, imem_data, zero_flag, output load, d, ir, ir_pc, ir_valid, stack_err);
endinterface

// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: instruction register, branch decode and return stack with one-bubble taken branches
module fetch_branch_unit #(
  parameter int STACK_DEPTH = 4
) (
  input logic clock,
  input logic reset,
  fetch_branch_unit_if.slave bus
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  logic [11:0] stk [STACK_DEPTH];
  logic [CW-1:0] cnt;
  logic [3:0] op;
  logic push, pop, full, empty;
  logic [11:0] top;
  always_comb begin
    op = bus.ir[15:12];
    push = bus.ir_valid && op == 4'hE;
    pop = bus.ir_valid && op == 4'hF;
    full = cnt == CW'(STACK_DEPTH);
    empty = cnt == '0;
    top = empty ? 12'h000 : stk[0];
    bus.load = bus.ir_valid && (op == 4'hC || push || pop || (op == 4'hD && bus.zero_flag));
    bus.d = !bus.load ? 12'h000 : pop ? top : bus.ir[11:0];
  end
  // stk[0] is the top; a push into a full stack shifts the oldest entry out the bottom
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bus.ir <= '0;
      bus.ir_pc <= '0;
      bus.ir_valid <= 1'b0;
      bus.stack_err <= 1'b0;
      cnt <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else begin
      bus.ir <= bus.imem_data;
      bus.ir_pc <= bus.pc;
      bus.ir_valid <= !bus.load;
      if (push) begin
        for (int i = STACK_DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
        stk[0] <= bus.ir_pc + 12'd1;
        cnt <= full ? cnt : cnt + CW'(1);
        if (full) bus.stack_err <= 1'b1;
      end else if (pop) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
        cnt <= empty ? cnt : cnt - CW'(1);
        if (empty) bus.stack_err <= 1'b1;
      end
    end
endmodule
